// File: rtl/muldiv_unit_pkg.sv
// Shared opcodes, FSM states and decode helpers for the RV32M multiply/divide unit.
// Latency: none (definitions only).
// Backpressure: not applicable.
package muldiv_unit_pkg;

  // Operation select, RISC-V funct3 encoding of the M extension
  localparam logic [2:0] MD_OP_MUL    = 3'b000;
  localparam logic [2:0] MD_OP_MULH   = 3'b001;
  localparam logic [2:0] MD_OP_MULHSU = 3'b010;
  localparam logic [2:0] MD_OP_MULHU  = 3'b011;
  localparam logic [2:0] MD_OP_DIV    = 3'b100;
  localparam logic [2:0] MD_OP_DIVU   = 3'b101;
  localparam logic [2:0] MD_OP_REM    = 3'b110;
  localparam logic [2:0] MD_OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_ST_IDLE  = 2'd0,
    MD_ST_BUSY  = 2'd1,
    MD_ST_FIXUP = 2'd2,
    MD_ST_DONE  = 2'd3
  } md_state_e;

  // funct3[2] separates the divide/remainder class from the multiplies
  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module muldiv_step
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        op_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
  always_comb begin
    hi      = acc_i[2*XLEN-1:XLEN];
    lo      = acc_i[XLEN-1:0];
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd_i} : '0);
    shifted = {hi, lo[XLEN-1]};
    // shifted < 2*divisor, so diff[XLEN] is a clean borrow flag
    diff    = shifted - {1'b0, opnd_i};
    if (md_is_div(op_i)) begin
      acc_o = diff[XLEN] ? {shifted[XLEN-1:0], lo[XLEN-2:0], 1'b0}
                         : {diff[XLEN-1:0],    lo[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {sum, lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with tag passthrough and flush; MULDIV_FAST_MUL_EN adds a one-shot multiplier.
// Latency: XLEN+2 cycles accept-to-response; 2 cycles for divide-by-zero, signed overflow and (fast build) multiplies.
// Backpressure: req_ready_o only in IDLE; result/tag held in DONE until resp_ready_i or flush_i.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       md_opcode_i,
  input  logic [XLEN-1:0]  op_1_i,
  input  logic [XLEN-1:0]  op_2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic [TAG_W-1:0]  tag_q, tag_out_q;
  logic [XLEN-1:0]   opnd_q, res_q;
  logic [2*XLEN-1:0] acc_q, acc_step;
  logic              neg_q;

  logic              accept, is_div, special;
  logic              op1_neg, op2_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   abs1, abs2, opnd_init;
  logic [2*XLEN-1:0] acc_init;
  logic              neg_init;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, res_fix;
`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN+1:0] fast_p;
`endif

  assign accept = req_valid_i && (state_q == MD_ST_IDLE) && !flush_i;
  assign is_div = md_is_div(md_opcode_i);

  // Request decode: magnitudes, result sign, and the early-out cases
  always_comb begin
    op1_neg   = op_1_i[XLEN-1] &&
                (md_opcode_i inside {MD_OP_MULH, MD_OP_MULHSU, MD_OP_DIV, MD_OP_REM});
    op2_neg   = op_2_i[XLEN-1] && (md_opcode_i inside {MD_OP_MULH, MD_OP_DIV, MD_OP_REM});
    abs1      = op1_neg ? (~op_1_i + 1'b1) : op_1_i;
    abs2      = op2_neg ? (~op_2_i + 1'b1) : op_2_i;
    div_zero  = is_div && (op_2_i == '0);
    div_ovf   = (md_opcode_i inside {MD_OP_DIV, MD_OP_REM}) &&
                (op_1_i == INT_MIN) && (op_2_i == '1);
    special   = div_zero || div_ovf;
    // remainder sign follows the dividend only; everything else is the xor
    neg_init  = (md_opcode_i == MD_OP_REM) ? op1_neg : (op1_neg ^ op2_neg);
    opnd_init = is_div ? abs2 : abs1;
    acc_init  = {{XLEN{1'b0}}, (is_div ? abs1 : abs2)};
    // Early-outs preload acc so FIXUP's normal select yields the answer unchanged
    if (div_zero) begin
      acc_init = {op_1_i, {XLEN{1'b1}}};
      neg_init = 1'b0;
    end else if (div_ovf) begin
      acc_init = {{XLEN{1'b0}}, op_1_i};
      neg_init = 1'b0;
    end
`ifdef MULDIV_FAST_MUL_EN
    fast_a = {op_1_i[XLEN-1] && (md_opcode_i inside {MD_OP_MULH, MD_OP_MULHSU}), op_1_i};
    fast_b = {op_2_i[XLEN-1] && (md_opcode_i == MD_OP_MULH), op_2_i};
    fast_p = fast_a * fast_b;
    if (!is_div) begin
      acc_init = fast_p[2*XLEN-1:0];
      neg_init = 1'b0;
      special  = 1'b1;
    end
`endif
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .op_i   (op_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= MD_ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state; flush beats both progress and the response handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_ST_IDLE:  if (accept) state_d = special ? MD_ST_FIXUP : MD_ST_BUSY;
      MD_ST_BUSY:  if (flush_i) state_d = MD_ST_IDLE;
                   else if (cnt_q == CNT_LAST) state_d = MD_ST_FIXUP;
      MD_ST_FIXUP: state_d = flush_i ? MD_ST_IDLE : MD_ST_DONE;
      MD_ST_DONE:  if (flush_i || resp_ready_i) state_d = MD_ST_IDLE;
      default:     state_d = MD_ST_IDLE;
    endcase
  end

  // Sign correction and result select out of the finished accumulator
  always_comb begin
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    res_fix  = prod_fix[XLEN-1:0];
    case (op_q)
      MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: res_fix = prod_fix[2*XLEN-1:XLEN];
      MD_OP_DIV, MD_OP_DIVU:                 res_fix = quo_fix;
      MD_OP_REM, MD_OP_REMU:                 res_fix = rem_fix;
      default:                               res_fix = prod_fix[XLEN-1:0];
    endcase
  end

  // Operand capture, iteration and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      tag_out_q <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      res_q     <= '0;
    end else begin
      if (accept) begin
        op_q   <= md_opcode_i;
        tag_q  <= tag_i;
        opnd_q <= opnd_init;
        acc_q  <= acc_init;
        neg_q  <= neg_init;
        cnt_q  <= '0;
      end else if (state_q == MD_ST_BUSY) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 1'b1;
      end
      // outputs only move when a response is about to be presented
      if (state_q == MD_ST_FIXUP && !flush_i) begin
        res_q     <= res_fix;
        tag_out_q <= tag_q;
      end
    end
  end

  assign req_ready_o  = (state_q == MD_ST_IDLE);
  assign resp_valid_o = (state_q == MD_ST_DONE);
  assign result_o     = res_q;
  assign tag_o        = tag_out_q;

endmodule
